// File: rtl/pc_gen_pkg.sv
// Shared constants for the PC generator: FSM encodings, hold level, reset address, step sizes.
// No logic here and so no latency or backpressure of its own.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_ST_RESET = 2'd0,
    PC_ST_RUN   = 2'd1,
    PC_ST_HALT  = 2'd2
  } pc_state_t;

  localparam int          HOLD_PC       = 1;
  localparam logic [31:0] PC_RESET_ADDR = 32'h0;
  localparam int          PC_STEP_C     = 2;
  localparam int          PC_STEP_W     = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request channel between the PC generator and the fetch bus master.
// Plain wires; a raised req waits on gnt, with no latency added here.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_o;
  logic              if_gnt_i;
  logic [ADDR_W-1:0] if_addr_o;

  modport master (output if_req_o, output if_addr_o, input if_gnt_i);
  modport slave  (input if_req_o, input if_addr_o, output if_gnt_i);
endinterface

// File: rtl/pc_redirect_arb.sv
// Picks one aligned redirect target per cycle (jtag > trap > jump).
// Purely combinational; it has no backpressure.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit C_EXT  = 1'b1
) (
  input  logic              jtag_flag,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              trap_flag,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] target
);

  always_comb begin
    redirect_valid = jtag_flag | trap_flag | jump_flag;
    if (jtag_flag)      target = jtag_addr;
    else if (trap_flag) target = trap_addr;
    else                target = jump_addr;
    target[0] = 1'b0;
    if (!C_EXT) target[1] = 1'b0;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: runs the RESET/RUN/HALT FSM and drives the fetch address over req/gnt.
// Redirects apply one edge later; a redirect that arrives during a stalled fetch is parked until gnt.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W        = 32,
  parameter logic [31:0] RESET_ADDR    = PC_RESET_ADDR,
  parameter int          HOLD_W        = 3,
  parameter int          HOLD_PC_LEVEL = HOLD_PC,
  parameter bit          C_EXT         = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_flag_i,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              compressed_i,
  input  logic              halt_req_i,
  input  logic              resume_i,
  pc_gen_if.master          fetch,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] RST_PC   = RESET_ADDR[ADDR_W-1:0];
  localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_PC_LEVEL);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pend_addr_q, target, step;
  logic              waiting_q, pend_valid_q, halted_q;
  logic              redirect_valid, req, gnt, fire, rst_all;

  assign rst_all = rst | jtag_reset_flag_i;
  assign gnt     = fetch.if_gnt_i;
  assign fire    = req & gnt;
  assign step    = (C_EXT && compressed_i) ? ADDR_W'(PC_STEP_C) : ADDR_W'(PC_STEP_W);

  pc_redirect_arb #(.ADDR_W(ADDR_W), .C_EXT(C_EXT)) u_arb (
    .jtag_flag      (jtag_reset_flag_i),
    .jtag_addr      (RST_PC),
    .trap_flag      (trap_flag_i),
    .trap_addr      (trap_addr_i),
    .jump_flag      (jump_flag_i),
    .jump_addr      (jump_addr_i),
    .redirect_valid (redirect_valid),
    .target         (target)
  );

  always_ff @(posedge clk) begin
    if (rst_all) state_q <= PC_ST_RESET;
    else         state_q <= state_d;
  end

  // Halt only once no fetch would be left stranded without a grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_ST_RESET: state_d = PC_ST_RUN;
      PC_ST_RUN:   if (halt_req_i && !(req && !gnt)) state_d = PC_ST_HALT;
      PC_ST_HALT:  if (resume_i) state_d = PC_ST_RUN;
      default:     state_d = PC_ST_RESET;
    endcase
  end

  always_comb begin
    req = (state_q == PC_ST_RUN) && (waiting_q || (hold_flag_i < HOLD_LVL));
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      pc_q         <= RST_PC;
      pend_addr_q  <= RST_PC;
      waiting_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      waiting_q <= req & ~gnt;
      halted_q  <= (state_d == PC_ST_HALT);
      if (redirect_valid && waiting_q && !gnt) begin
        pend_addr_q  <= target;
        pend_valid_q <= 1'b1;
      end else if (redirect_valid) begin
        pc_q         <= target;
        pend_valid_q <= 1'b0;
      end else if (fire && pend_valid_q) begin
        pc_q         <= pend_addr_q;
        pend_valid_q <= 1'b0;
      end else if (fire) begin
        pc_q <= pc_q + step;
      end
    end
  end

  assign fetch.if_req_o  = req;
  assign fetch.if_addr_o = pc_q;
  assign pc_o            = pc_q;
  assign halted_o        = halted_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator that succeeds the single-width PC register. It drives the instruction-fetch address with a req/gnt handshake and supports 2- or 4-byte sequential steps. It accepts prioritised redirects (JTAG reset, trap, jump) and parks redirects that arrive while a fetch is still awaiting grant. It also adds a debug halt/resume state. It sits between the control/hold logic and the instruction-fetch bus master.

## Interface
- ADDR_W, 32, PC/fetch address width
- RESET_ADDR, 32'h0, PC value after rst or JTAG reset (ADDR_W bits used)
- HOLD_W, 3, width of hold_flag_i
- HOLD_PC_LEVEL, 1, hold_flag_i >= this value stalls new fetches
- C_EXT, 1, 1 = 2-byte step allowed; 0 = always 4-byte
- clk  in  1  single clock; all state changes on posedge clk
- rst  in  1  reset, synchronous, active-high
- jtag_reset_flag_i  in  1  debug reset; same effect as rst
- trap_flag_i  in  1  trap/interrupt redirect valid
- trap_addr_i  in  ADDR_W  trap target
- jump_flag_i  in  1  branch/jump redirect valid
- jump_addr_i  in  ADDR_W  jump target
- hold_flag_i  in  HOLD_W  pipeline hold level
- compressed_i  in  1  granted instruction is 16-bit; ignored when C_EXT=0
- halt_req_i  in  1  debug halt request (level)
- resume_i  in  1  debug resume pulse
- if_gnt_i  in  1  fetch bus grant
- if_req_o  out  1  fetch request
- if_addr_o  out  ADDR_W  fetch address, equal to pc_o
- pc_o  out  ADDR_W  current PC
- halted_o  out  1  core fetch halted

## Operation
- States: RESET, RUN, HALT. rst or jtag_reset_flag_i forces RESET from any state.
- RESET lasts one cycle after reset deasserts, then goes to RUN.
- RUN goes to HALT when halt_req_i=1 and no fetch is waiting. HALT goes to RUN on resume_i.
- waiting register: set when if_req_o && !if_gnt_i; cleared on grant.
- if_req_o = (state==RUN) && (waiting || hold_flag_i < HOLD_PC_LEVEL). A raised request is never withdrawn before grant, except on rst or JTAG reset.
- Redirect priority: JTAG reset > trap > jump. The sub-block produces one target per cycle.
- Alignment: target bit 0 is forced to 0. When C_EXT=0, bits [1:0] are forced to 0.
- Next-PC, first match wins:
  - reset: RESET_ADDR.
  - Redirect while waiting && !if_gnt_i: pc_o unchanged. Target goes to pend_addr and pend_valid is set; a later redirect overwrites it.
  - Redirect otherwise (RUN, HALT, on grant, or under hold): pc_o <= target, and pend_valid is cleared.
  - Grant with pend_valid: pc_o <= pend_addr, and pend_valid is cleared.
  - Grant: pc_o <= pc_o + step, where step = (C_EXT && compressed_i) ? 2 : 4.
  - Else: hold pc_o.
- All addition is modulo 2^ADDR_W, so wrap-around is silent.
- In HALT: if_req_o=0. Jump and trap still load pc_o, which is how the debugger sets the PC.
- Reset clears waiting and pend_valid.

## Timing
- Reset values: pc_o=RESET_ADDR, if_addr_o=RESET_ADDR, if_req_o=0, halted_o=0. Internal state=RESET.
- First request: rst deasserts before edge N. State is RESET during cycle N and RUN at N+1, so if_req_o=1 from cycle N+1.
- A redirect without waiting is applied one edge later: if_addr_o shows the target the next cycle.
- A parked redirect appears one cycle after the grant of the stale fetch, with no extra bubble.
- Throughput: one fetch address per cycle when if_gnt_i is held high.
- if_req_o depends combinationally on hold_flag_i. All other outputs are registered.
- halted_o=1 in the cycle after entering HALT, and 0 in the cycle after resume.
- resume_i in RUN is ignored. halt_req_i while waiting is deferred until grant.

## Structure
- Shared defines file holds:
  - state encodings PC_ST_RESET/RUN/HALT (2 bits)
  - Hold_Pc level
  - the default reset address
  - step constants
- Sub-module pc_redirect_arb is combinational. It takes the three flag/address pairs and produces redirect_valid and the aligned target.
- The top module holds the FSM, pc_o, waiting, pend_valid and pend_addr.

## Test plan
- Reset/sequential: RESET_ADDR=0x100, release rst, if_gnt_i=1, C_EXT=1, compressed_i pattern 0,1,1,0 -> if_addr_o = 0x100, 0x104, 0x106, 0x108, 0x10C, with if_req_o first high one cycle after release.
- Parked redirect: request to 0x200, hold if_gnt_i=0 for 3 cycles, jump to 0x400 in cycle 1 and trap to 0x80 in cycle 2 -> if_addr_o stays 0x200 until grant, then 0x80; 0x400 is never fetched.
- Priority/alignment: trap 0x300 with jump 0x501 in the same cycle -> 0x300. Jump 0x503 alone with C_EXT=0 -> 0x500.
- Hold: hold_flag_i=HOLD_PC_LEVEL at pc 0x10 while not waiting -> if_req_o=0, pc stays 0x10. Hold asserted while waiting -> if_req_o stays 1 until grant.
- Halt/resume: halt_req_i in RUN -> halted_o=1, if_req_o=0. Jump to 0x700 while halted, then resume_i -> first request at 0x700.
- Wrap/JTAG reset: ADDR_W=16, pc 0xFFFC, grant -> 0x0000. jtag_reset_flag_i during waiting -> if_req_o=0 next cycle, pc=RESET_ADDR, pend_valid cleared.
